// File: rtl/piece_fall_controller_pkg.sv
// Shared types and defaults for the falling-piece sequencer.
// Optional feature macro: LOCK_RESET_LIMIT_EN (caps lock-timer resets per piece).
package piece_fall_controller_pkg;

    // Life-cycle phase of the active piece; values are visible on the HUD port.
    typedef enum logic [2:0] {
        FS_IDLE      = 3'd0,
        FS_SPAWN     = 3'd1,
        FS_FALLING   = 3'd2,
        FS_HARD_DROP = 3'd3,
        FS_GROUNDED  = 3'd4,
        FS_LOCKING   = 3'd5,
        FS_GAME_OVER = 3'd6
    } fall_state_t;

    // 0.5 s at 50 MHz.
    localparam int LOCK_DELAY_DEFAULT      = 25_000_000;
    localparam int MAX_LOCK_RESETS_DEFAULT = 15;

endpackage

// File: rtl/piece_fall_controller_counter.sv
// Generic loadable up/down counter used as the lock-delay timer.
module piece_fall_controller_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load has priority over counting; reset clears the count.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= up ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/piece_fall_controller.sv
// Falling-piece sequencer: spawn, gravity/soft/hard drop, lock delay, lock, respawn.
// Optional feature macro: LOCK_RESET_LIMIT_EN. When defined, successful moves may
// restart the lock timer at most MAX_LOCK_RESETS times per piece; otherwise every
// move in GROUNDED restarts it.
//
// Handshakes: spawn_req and lock_req are level requests (valid). They stay high
// until the matching ack (ready) is sampled high at a clock edge; the request then
// drops on that same edge. Acks seen while no request is outstanding are ignored.
module piece_fall_controller
    import piece_fall_controller_pkg::*;
#(
    parameter int LOCK_DELAY_CYCLES = LOCK_DELAY_DEFAULT,
    parameter int MAX_LOCK_RESETS   = MAX_LOCK_RESETS_DEFAULT,
    parameter int CNT_WIDTH         = 32
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       game_active,
    input  logic       auto_drop,
    input  logic       soft_drop,
    input  logic       hard_drop,
    input  logic       player_move,
    input  logic       drop_blocked,
    input  logic       spawn_ack,
    input  logic       spawn_blocked,
    input  logic       lock_ack,
    output logic       drop_down,
    output logic       spawn_req,
    output logic       lock_req,
    output logic       gravity_restart,
    output logic       game_over,
    output logic [2:0] fall_state
);

    localparam logic [2:0] ST_IDLE      = FS_IDLE;
    localparam logic [2:0] ST_SPAWN     = FS_SPAWN;
    localparam logic [2:0] ST_FALLING   = FS_FALLING;
    localparam logic [2:0] ST_HARD_DROP = FS_HARD_DROP;
    localparam logic [2:0] ST_GROUNDED  = FS_GROUNDED;
    localparam logic [2:0] ST_LOCKING   = FS_LOCKING;
    localparam logic [2:0] ST_GAME_OVER = FS_GAME_OVER;

    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(LOCK_DELAY_CYCLES - 1);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [CNT_WIDTH-1:0] timer_q;
    logic                 timer_load;
    logic                 timer_expired;
    logic                 drop_cmd;
    logic                 spawn_ok;
    logic                 move_reset;
    logic                 can_reset;

    assign timer_expired = (timer_q == TIMER_LAST);

`ifdef LOCK_RESET_LIMIT_EN
    localparam int RC_W = $clog2(MAX_LOCK_RESETS + 1);
    logic [RC_W-1:0] reset_cnt_q;

    assign can_reset = (reset_cnt_q < RC_W'(MAX_LOCK_RESETS));

    // Per-piece count of timer restarts; cleared on each spawn, saturates at the cap.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            reset_cnt_q <= '0;
        end else if (spawn_ok) begin
            reset_cnt_q <= '0;
        end else if (move_reset) begin
            reset_cnt_q <= reset_cnt_q + 1'b1;
        end
    end
`else
    // Unlimited restarts; the comparison is constant-true and only keeps the
    // parameter referenced in this build.
    assign can_reset = (MAX_LOCK_RESETS >= 0);
`endif

    // Next-state and one-shot decisions; event priority follows each state's list.
    always_comb begin
        state_d    = state_q;
        drop_cmd   = 1'b0;
        spawn_ok   = 1'b0;
        move_reset = 1'b0;
        if (!game_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SPAWN;
                ST_SPAWN: begin
                    if (spawn_ack) begin
                        if (spawn_blocked) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d  = ST_FALLING;
                            spawn_ok = 1'b1;
                        end
                    end
                end
                ST_FALLING: begin
                    if (hard_drop) begin
                        state_d = ST_HARD_DROP;
                    end else if (drop_blocked) begin
                        state_d = ST_GROUNDED;
                    end else if (auto_drop || soft_drop) begin
                        drop_cmd = 1'b1;
                    end
                end
                ST_HARD_DROP: begin
                    if (drop_blocked) begin
                        state_d = ST_LOCKING;
                    end else begin
                        drop_cmd = 1'b1;
                    end
                end
                ST_GROUNDED: begin
                    if (hard_drop) begin
                        state_d = ST_LOCKING;
                    end else if (!drop_blocked) begin
                        state_d = ST_FALLING;
                    end else if (timer_expired) begin
                        state_d = ST_LOCKING;
                    end else if (player_move && can_reset) begin
                        move_reset = 1'b1;
                    end
                end
                ST_LOCKING: begin
                    if (lock_ack) begin
                        state_d = ST_SPAWN;
                    end
                end
                ST_GAME_OVER: state_d = ST_GAME_OVER;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Timer clears whenever the piece is not staying grounded, or on a move reset,
    // so it never counts past the expiry value.
    assign timer_load = (state_q != ST_GROUNDED) || (state_d != ST_GROUNDED) || move_reset;

    piece_fall_controller_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_lock_timer (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (state_q == ST_GROUNDED),
        .load  (timer_load),
        .up    (1'b1),
        .d     ('0),
        .q     (timer_q)
    );

    // State register and registered outputs, all derived from this cycle's decision.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q         <= ST_IDLE;
            drop_down       <= 1'b0;
            spawn_req       <= 1'b0;
            lock_req        <= 1'b0;
            gravity_restart <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            state_q         <= state_d;
            drop_down       <= drop_cmd;
            spawn_req       <= (state_d == ST_SPAWN);
            lock_req        <= (state_d == ST_LOCKING);
            gravity_restart <= spawn_ok;
            game_over       <= (state_d == ST_GAME_OVER);
        end
    end

    assign fall_state = state_q;

endmodule

// File: tb/tb_piece_fall_controller.sv
// Directed bench for piece_fall_controller (LOCK_DELAY_CYCLES=8, MAX_LOCK_RESETS=2).
// Expectations for the lock-reset scenario follow LOCK_RESET_LIMIT_EN.
module tb_piece_fall_controller;
    import piece_fall_controller_pkg::*;

`ifdef LOCK_RESET_LIMIT_EN
    localparam int EXP_TAIL = 2;
`else
    localparam int EXP_TAIL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       game_active = 1'b0;
    logic       auto_drop = 1'b0;
    logic       soft_drop = 1'b0;
    logic       hard_drop = 1'b0;
    logic       player_move = 1'b0;
    logic       drop_blocked = 1'b0;
    logic       spawn_ack = 1'b0;
    logic       spawn_blocked = 1'b0;
    logic       lock_ack = 1'b0;
    logic       drop_down;
    logic       spawn_req;
    logic       lock_req;
    logic       gravity_restart;
    logic       game_over;
    logic [2:0] fall_state;

    int errors = 0;
    int checks = 0;

    piece_fall_controller #(
        .LOCK_DELAY_CYCLES (8),
        .MAX_LOCK_RESETS   (2),
        .CNT_WIDTH         (32)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .game_active     (game_active),
        .auto_drop       (auto_drop),
        .soft_drop       (soft_drop),
        .hard_drop       (hard_drop),
        .player_move     (player_move),
        .drop_blocked    (drop_blocked),
        .spawn_ack       (spawn_ack),
        .spawn_blocked   (spawn_blocked),
        .lock_ack        (lock_ack),
        .drop_down       (drop_down),
        .spawn_req       (spawn_req),
        .lock_req        (lock_req),
        .gravity_restart (gravity_restart),
        .game_over       (game_over),
        .fall_state      (fall_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers: close a lock handshake and then accept the next spawn.
    task automatic lock_then_spawn();
        lock_ack = 1'b1; tick(); lock_ack = 1'b0;
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; game_active = 1'b1;
        tick(); tick();
        checks++; if (fall_state !== 3'(FS_IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fall_state, FS_IDLE); end
        checks++; if ({drop_down, spawn_req, lock_req, gravity_restart, game_over} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {drop_down, spawn_req, lock_req, gravity_restart, game_over}); end
        game_active = 1'b0;
        rst_l = 1'b1;
        tick();
    endtask

    task automatic test_spawn();
        game_active = 1'b1;
        tick();
        checks++; if (fall_state !== 3'(FS_SPAWN)) begin errors++; $display("FAIL spawn_enter: got %0d expected %0d", fall_state, FS_SPAWN); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (spawn_req !== 1'b1) begin errors++; $display("FAIL spawn_req_held[%0d]: got %b expected 1", i, spawn_req); end
            spawn_ack = (i == 2);
            tick();
        end
        spawn_ack = 1'b0;
        checks++; if (fall_state !== 3'(FS_FALLING)) begin errors++; $display("FAIL spawn_falling: got %0d expected %0d", fall_state, FS_FALLING); end
        checks++; if ({spawn_req, gravity_restart} !== 2'b01) begin errors++; $display("FAIL spawn_restart: got req/restart %b expected 01", {spawn_req, gravity_restart}); end
        tick();
        checks++; if (gravity_restart !== 1'b0) begin errors++; $display("FAIL restart_single: got %b expected 0", gravity_restart); end
    endtask

    task automatic test_drop_merge();
        int pulses;
        pulses = 0;
        auto_drop = 1'b1; soft_drop = 1'b1;
        tick();
        auto_drop = 1'b0; soft_drop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulses += int'(drop_down);
            tick();
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_merge: got %0d pulses expected 1", pulses); end
        drop_blocked = 1'b1;
        tick();
        checks++; if (fall_state !== 3'(FS_GROUNDED)) begin errors++; $display("FAIL grounded: got %0d expected %0d", fall_state, FS_GROUNDED); end
        for (int i = 1; i < 8; i++) begin
            auto_drop = (i == 3);
            tick();
            auto_drop = 1'b0;
            checks++; if ({lock_req, drop_down} !== 2'b00) begin errors++; $display("FAIL lock_wait[%0d]: got lock/drop %b expected 00", i, {lock_req, drop_down}); end
        end
        tick();
        checks++; if (lock_req !== 1'b1 || fall_state !== 3'(FS_LOCKING)) begin errors++; $display("FAIL lock_after_8: got lock_req=%b state=%0d expected 1 and %0d", lock_req, fall_state, FS_LOCKING); end
        lock_then_spawn();
        checks++; if (fall_state !== 3'(FS_GROUNDED) && fall_state !== 3'(FS_FALLING)) begin errors++; $display("FAIL respawn: got %0d expected %0d", fall_state, FS_FALLING); end
    endtask

    task automatic test_lock_reset();
        int n;
        // drop_blocked is still high: the new piece grounds on the next edge.
        tick();
        checks++; if (fall_state !== 3'(FS_GROUNDED)) begin errors++; $display("FAIL lr_grounded: got %0d expected %0d", fall_state, FS_GROUNDED); end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) tick();
            player_move = 1'b1; tick(); player_move = 1'b0;
            checks++; if (fall_state !== 3'(FS_GROUNDED) || lock_req !== 1'b0) begin errors++; $display("FAIL lr_move[%0d]: got state=%0d lock_req=%b expected %0d and 0", r, fall_state, lock_req, FS_GROUNDED); end
        end
        n = 0;
        while (lock_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== EXP_TAIL) begin errors++; $display("FAIL lr_tail: got %0d cycles to lock expected %0d", n, EXP_TAIL); end
        drop_blocked = 1'b0;
        lock_then_spawn();
        checks++; if (fall_state !== 3'(FS_FALLING)) begin errors++; $display("FAIL lr_respawn: got %0d expected %0d", fall_state, FS_FALLING); end
    endtask

    task automatic test_hard_drop();
        int pulses;
        hard_drop = 1'b1; tick(); hard_drop = 1'b0;
        checks++; if (fall_state !== 3'(FS_HARD_DROP) || drop_down !== 1'b0) begin errors++; $display("FAIL hd_enter: got state=%0d drop=%b expected %0d and 0", fall_state, drop_down, FS_HARD_DROP); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drop_blocked = (i >= 4);
            tick();
            pulses += int'(drop_down);
            checks++; if (drop_down !== (i < 4)) begin errors++; $display("FAIL hd_pulse[%0d]: got %b expected %b", i, drop_down, (i < 4)); end
        end
        checks++; if (pulses !== 4 || lock_req !== 1'b1) begin errors++; $display("FAIL hd_lock: got pulses=%0d lock_req=%b expected 4 and 1", pulses, lock_req); end
        lock_then_spawn();
        // Already grounded at the moment of the hard drop: no rows to fall.
        hard_drop = 1'b1; tick(); hard_drop = 1'b0;
        tick();
        checks++; if (lock_req !== 1'b1 || drop_down !== 1'b0) begin errors++; $display("FAIL hd_blocked: got lock_req=%b drop=%b expected 1 and 0", lock_req, drop_down); end
        lock_then_spawn();
        tick();
        checks++; if (fall_state !== 3'(FS_GROUNDED)) begin errors++; $display("FAIL hd_g_enter: got %0d expected %0d", fall_state, FS_GROUNDED); end
        hard_drop = 1'b1; tick(); hard_drop = 1'b0;
        checks++; if (lock_req !== 1'b1 || drop_down !== 1'b0 || fall_state !== 3'(FS_LOCKING)) begin errors++; $display("FAIL hd_grounded: got lock_req=%b drop=%b state=%0d expected 1 0 %0d", lock_req, drop_down, fall_state, FS_LOCKING); end
    endtask

    task automatic test_top_out();
        lock_ack = 1'b1; tick(); lock_ack = 1'b0;
        checks++; if (spawn_req !== 1'b1 || lock_req !== 1'b0) begin errors++; $display("FAIL to_spawn: got spawn_req=%b lock_req=%b expected 1 and 0", spawn_req, lock_req); end
        spawn_ack = 1'b1; spawn_blocked = 1'b1; tick(); spawn_ack = 1'b0; spawn_blocked = 1'b0;
        checks++; if (game_over !== 1'b1 || fall_state !== 3'(FS_GAME_OVER) || gravity_restart !== 1'b0) begin errors++; $display("FAIL top_out: got go=%b state=%0d restart=%b expected 1 %0d 0", game_over, fall_state, gravity_restart, FS_GAME_OVER); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_held: got %b expected 1", game_over); end
        game_active = 1'b0; tick();
        checks++; if (game_over !== 1'b0 || fall_state !== 3'(FS_IDLE)) begin errors++; $display("FAIL go_exit: got go=%b state=%0d expected 0 %0d", game_over, fall_state, FS_IDLE); end
    endtask

    task automatic test_abort();
        game_active = 1'b1; tick();
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
        tick();
        hard_drop = 1'b1; tick(); hard_drop = 1'b0;
        checks++; if (lock_req !== 1'b1) begin errors++; $display("FAIL abort_pre: got lock_req=%b expected 1", lock_req); end
        game_active = 1'b0; tick();
        checks++; if (lock_req !== 1'b0 || fall_state !== 3'(FS_IDLE)) begin errors++; $display("FAIL abort: got lock_req=%b state=%0d expected 0 %0d", lock_req, fall_state, FS_IDLE); end
        lock_ack = 1'b1; tick(); lock_ack = 1'b0;
        checks++; if (fall_state !== 3'(FS_IDLE) || spawn_req !== 1'b0) begin errors++; $display("FAIL late_ack: got state=%0d spawn_req=%b expected %0d 0", fall_state, spawn_req, FS_IDLE); end
        game_active = 1'b1; tick();
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
        tick(); tick();
        checks++; if (fall_state !== 3'(FS_GROUNDED)) begin errors++; $display("FAIL mid_grounded: got %0d expected %0d", fall_state, FS_GROUNDED); end
        rst_l = 1'b0; tick();
        checks++; if (fall_state !== 3'(FS_IDLE) || {drop_down, spawn_req, lock_req, gravity_restart, game_over} !== 5'b0) begin errors++; $display("FAIL mid_reset: got state=%0d outs=%b expected %0d 00000", fall_state, {drop_down, spawn_req, lock_req, gravity_restart, game_over}, FS_IDLE); end
        rst_l = 1'b1; game_active = 1'b0; drop_blocked = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_drop_merge();
        test_lock_reset();
        test_hard_drop();
        test_top_out();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
